// File: rtl/cla_pipe_adder_if.sv
// Valid/ready operand and result stream for the pipelined CLA adder/subtractor.
// The adder attaches through the slave modport; the producer/consumer side uses master.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Carry-pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group
// per stage, NBLK = WIDTH/BLOCK stages, one operation per cycle, global stall.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end

    // Every carry is a flat sum of products of g/p terms, so the group has no ripple chain.
    function automatic logic [BLOCK:0] lookahead(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             c0
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic adv;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int LO = k * BLOCK;
        localparam int OW = WIDTH - LO;

        logic [OW-1:0]       src_a, src_b;
        logic                src_sub, src_c, src_v, ld;
        logic [BLOCK-1:0]    blk_b, bp, bg, bs;
        logic [BLOCK:0]      bc;
        logic                vld_q, vld_d;
        logic                cry_q, cry_d;
        logic [LO+BLOCK-1:0] res_q, res_d;

        // Operands shift down as they travel, so this stage's group is always bits [BLOCK-1:0].
        if (k == 0) begin : g_src
            always_comb begin
                src_a   = bus.a;
                src_b   = bus.b;
                src_sub = bus.sub;
                src_c   = bus.cin ^ bus.sub;
                src_v   = bus.in_valid;
                ld      = adv & bus.in_valid;
            end
        end else begin : g_src
            always_comb begin
                src_a   = g_stg[k-1].g_up.opa_q;
                src_b   = g_stg[k-1].g_up.opb_q;
                src_sub = g_stg[k-1].g_up.sub_q;
                src_c   = g_stg[k-1].cry_q;
                src_v   = g_stg[k-1].vld_q;
                ld      = adv;
            end
        end

        always_comb begin
            blk_b = src_b[BLOCK-1:0] ^ {BLOCK{src_sub}};
            bp    = src_a[BLOCK-1:0] ^ blk_b;
            bg    = src_a[BLOCK-1:0] & blk_b;
            bc    = lookahead(bp, bg, src_c);
            bs    = bp ^ bc[BLOCK-1:0];
            vld_d = adv ? src_v : vld_q;
            cry_d = ld ? bc[BLOCK] : cry_q;
        end

        if (k == 0) begin : g_res
            always_comb res_d = ld ? bs : res_q;
        end else begin : g_res
            always_comb res_d = ld ? {bs, g_stg[k-1].res_q} : res_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                res_q <= '0;
            end else begin
                vld_q <= vld_d;
                cry_q <= cry_d;
                res_q <= res_d;
            end
        end

        if (OW > BLOCK) begin : g_up
            logic [OW-BLOCK-1:0] opa_q, opa_d;
            logic [OW-BLOCK-1:0] opb_q, opb_d;
            logic                sub_q, sub_d;

            always_comb begin
                opa_d = ld ? src_a[OW-1:BLOCK] : opa_q;
                opb_d = ld ? src_b[OW-1:BLOCK] : opb_q;
                sub_d = ld ? src_sub : sub_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    sub_q <= 1'b0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    sub_q <= sub_d;
                end
            end
        end

        // Carry into the MSB, kept alongside cout for the overflow flag.
        if (k == NBLK - 1) begin : g_last
            logic cmsb_q, cmsb_d;

            always_comb cmsb_d = ld ? bc[BLOCK-1] : cmsb_q;

            always_ff @(posedge clk) begin
                if (!rst_n) cmsb_q <= 1'b0;
                else        cmsb_q <= cmsb_d;
            end
        end
    end

    always_comb adv = bus.out_ready | ~g_stg[NBLK-1].vld_q;

    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stg[NBLK-1].vld_q;
    assign bus.sum       = g_stg[NBLK-1].res_q;
    assign bus.cout      = g_stg[NBLK-1].cry_q;
    assign bus.ovf       = g_stg[NBLK-1].g_last.cmsb_q ^ g_stg[NBLK-1].cry_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomised checks of cla_pipe_adder at 16/4, 8/8 and 32/4.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(16)) if16 ();
    cla_pipe_adder_if #(.WIDTH(8))  if8  ();
    cla_pipe_adder_if #(.WIDTH(32)) if32 ();

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    cla_pipe_adder #(.WIDTH(8),  .BLOCK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    cla_pipe_adder #(.WIDTH(32), .BLOCK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    int n_cmp = 0;
    int n_err = 0;

    logic        o_v [3];
    logic        o_r [3];
    logic        o_c [3];
    logic        o_o [3];
    logic [31:0] o_s [3];

    always_comb begin
        o_v[0] = if16.out_valid; o_r[0] = if16.in_ready; o_c[0] = if16.cout;
        o_o[0] = if16.ovf;       o_s[0] = 32'(if16.sum);
        o_v[1] = if8.out_valid;  o_r[1] = if8.in_ready;  o_c[1] = if8.cout;
        o_o[1] = if8.ovf;        o_s[1] = 32'(if8.sum);
        o_v[2] = if32.out_valid; o_r[2] = if32.in_ready; o_c[2] = if32.cout;
        o_o[2] = if32.ovf;       o_s[2] = if32.sum;
    end

    // Stall-test operations with hand-computed results.
    logic [15:0] ta  [5] = '{16'h0001, 16'h00F0, 16'h0F00, 16'h7000, 16'h0003};
    logic [15:0] tb  [5] = '{16'h0002, 16'h0010, 16'h0100, 16'h1000, 16'h0003};
    logic        tsb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] tes [5] = '{16'h0003, 16'h0100, 16'h1000, 16'h8000, 16'h0000};
    logic        tec [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        teo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int sel, input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic ordy);
        case (sel)
            0: begin
                if16.in_valid = iv; if16.a = a[15:0]; if16.b = b[15:0];
                if16.cin = cin; if16.sub = sub; if16.out_ready = ordy;
            end
            1: begin
                if8.in_valid = iv; if8.a = a[7:0]; if8.b = b[7:0];
                if8.cin = cin; if8.sub = sub; if8.out_ready = ordy;
            end
            default: begin
                if32.in_valid = iv; if32.a = a; if32.b = b;
                if32.cin = cin; if32.sub = sub; if32.out_ready = ordy;
            end
        endcase
    endtask

    // Reference: {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] mask, beff, s;
        logic [32:0] full;
        logic        c0, co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        beff = (sub ? ~b : b) & mask;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a & mask} + {1'b0, beff} + {32'h0, c0};
        s    = full[31:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        drv(0, 1'b1, 32'(a), 32'(b), cin, sub, 1'b1);
        @(negedge clk);
        chk({tag, "_in_ready"}, o_r[0], 1'b1);
        @(posedge clk); #1;
        drv(0, 1'b0, 32'(a), 32'(b), cin, sub, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_early_valid"}, o_v[0], 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk(tag, {o_v[0], o_c[0], o_o[0], o_s[0][15:0]}, {1'b1, ec, eo, es});
        @(posedge clk); #1;
    endtask

    task automatic run_rand(input string tag, input int sel, input int w, input int nblk, input int n);
        logic [31:0] q_s [$];
        logic        q_c [$];
        logic        q_o [$];
        int          q_t [$];
        logic [31:0] mask, ra, rb, s, ps;
        logic [33:0] m;
        logic        iv, rc, rsub, ordy, v, r, c, o, pv, pc, po;
        int          advcnt, sent, got, cyc;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        advcnt = 0; sent = 0; got = 0; cyc = 0;
        pv = 1'b0; ps = '0; pc = 1'b0; po = 1'b0;
        while ((sent < n || got < n) && cyc < 2000) begin
            iv   = (sent < n) && ($urandom_range(0, 3) != 0);
            ra   = $urandom & mask;
            rb   = $urandom & mask;
            rc   = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 2) != 0);
            drv(sel, iv, ra, rb, rc, rsub, ordy);
            @(negedge clk);
            v = o_v[sel]; r = o_r[sel]; s = o_s[sel]; c = o_c[sel]; o = o_o[sel];
            chk({tag, "_in_ready"}, r, !(v && !ordy));
            if (pv) chk({tag, "_hold"}, {v, c, o, s}, {1'b1, pc, po, ps});
            if (v && ordy) begin
                chk({tag, "_queue_nonempty"}, q_s.size() > 0, 1'b1);
                if (q_s.size() > 0) begin
                    chk({tag, "_result"}, {c, o, s}, {q_c.pop_front(), q_o.pop_front(), q_s.pop_front()});
                    chk({tag, "_latency"}, advcnt, q_t.pop_front());
                end
                got++;
            end
            if (iv && r) begin
                m = model(w, ra, rb, rc, rsub);
                q_s.push_back(m[31:0]);
                q_c.push_back(m[32]);
                q_o.push_back(m[33]);
                q_t.push_back(advcnt + nblk);
                sent++;
            end
            if (r) advcnt++;
            pv = v && !ordy; ps = s; pc = c; po = o;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_all_sent"}, sent, n);
        chk({tag, "_all_received"}, got, n);
        drv(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int ovcnt;
        rst_n = 1'b0;
        drv(0, 1'b1, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1);
        drv(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drv(2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Reset held for three edges with a valid operand presented.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_out_valid", o_v[0], 1'b0);
            chk("rst_sum", o_s[0], 32'h0);
            chk("rst_cout", o_c[0], 1'b0);
            chk("rst_ovf", o_o[0], 1'b0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        drv(0, 1'b0, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_in_ready", o_r[0], 1'b1);
        chk("post_rst_out_valid", o_v[0], 1'b0);
        ovcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            ovcnt += int'(o_v[0]);
        end
        chk("rst_no_result", ovcnt, 0);
        @(posedge clk); #1;

        check_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        check_op("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        check_op("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        check_op("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Fill the pipe with the consumer stalled, hold a fifth operand, then drain.
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 32'(ta[i]), 32'(tb[i]), 1'b0, tsb[i], 1'b0);
            @(negedge clk);
            chk("stall_fill_in_ready", o_r[0], 1'b1);
            @(posedge clk); #1;
        end
        drv(0, 1'b1, 32'(ta[4]), 32'(tb[4]), 1'b0, tsb[4], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_full_in_ready", o_r[0], 1'b0);
            chk("stall_hold_out", {o_v[0], o_c[0], o_o[0], o_s[0][15:0]}, {1'b1, tec[0], teo[0], tes[0]});
            @(posedge clk); #1;
        end
        drv(0, 1'b1, 32'(ta[4]), 32'(tb[4]), 1'b0, tsb[4], 1'b1);
        @(negedge clk);
        chk("drain_in_ready", o_r[0], 1'b1);
        chk("drain_op0", {o_v[0], o_c[0], o_o[0], o_s[0][15:0]}, {1'b1, tec[0], teo[0], tes[0]});
        @(posedge clk); #1;
        drv(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("drain_op", {o_v[0], o_c[0], o_o[0], o_s[0][15:0]}, {1'b1, tec[i], teo[i], tes[i]});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_empty", o_v[0], 1'b0);
        @(posedge clk); #1;

        // Three operations in flight, then a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            drv(0, 1'b1, 32'(ta[i]), 32'(tb[i]), 1'b0, tsb[i], 1'b1);
            @(posedge clk); #1;
        end
        drv(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ovcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ovcnt += int'(o_v[0]);
            @(posedge clk); #1;
        end
        chk("midrst_no_result", ovcnt, 0);
        check_op("after_midrst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        run_rand("rand16", 0, 16, 4, 64);
        run_rand("rand8",  1, 8,  1, 40);
        run_rand("rand32", 2, 32, 8, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
